// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port synchronous 32-bit memory between instruction fetch
// (IF) and the MEM-stage data port (DM). At most one access is granted per
// cycle. DM has fixed priority, except that IF is forced through after losing
// STARVE_LIMIT consecutive contested cycles. Accepted accesses pass through a
// registered command stage (drives the memory) and a response-tag stage
// (steers mem_rdata back to the owner). Read data therefore returns two cycles
// after acceptance.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request and word address
//   if_flush              cancel fetches already in flight
//   if_ready              fetch accepted this cycle (combinational)
//   if_valid/if_rdata     fetch response
//   dm_rd/dm_wr/dm_addr   data request (write wins if both high)
//   dm_wdata              data write value
//   dm_ready              data access accepted this cycle (combinational)
//   dm_valid/dm_rdata     read data or write acknowledge (data 0)
//   mem_en/mem_we         memory strobe and write enable
//   mem_addr/mem_wdata    memory address and write data
//   mem_rdata             memory read data, valid the cycle after mem_en
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ready,
  output logic              dm_valid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    OWN_DM = 1'b0,
    OWN_IF = 1'b1
  } own_t;

  logic              dm_req;
  logic              starve_hit;
  logic [CNT_W-1:0]  starve_cnt;

  logic              s1_vld;
  own_t              s1_own;
  logic              s1_we;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_wdata;

  logic              s2_vld;
  own_t              s2_own;
  logic              s2_we;

  // Grant: DM wins unless IF has been starved to the limit.
  assign dm_req     = dm_rd | dm_wr;
  assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign dm_ready   = !reset & dm_req & !(if_req & starve_hit);
  assign if_ready   = !reset & if_req & (!dm_req | starve_hit);

  // Consecutive contested cycles lost by IF, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_ready) begin
      starve_cnt <= '0;
    end else if (dm_ready && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Command stage: holds the granted access while it is presented to memory.
  // A new grant is never cancelled by a flush in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      s1_own   <= OWN_DM;
      s1_we    <= 1'b0;
      s1_addr  <= '0;
      s1_wdata <= '0;
    end else begin
      s1_vld <= dm_ready | if_ready;
      if (dm_ready) begin
        s1_own   <= OWN_DM;
        s1_we    <= dm_wr;
        s1_addr  <= dm_addr;
        s1_wdata <= dm_wdata;
      end else if (if_ready) begin
        s1_own   <= OWN_IF;
        s1_we    <= 1'b0;
        s1_addr  <= if_addr;
        s1_wdata <= '0;
      end
    end
  end

  // Response tag: a flush drops an IF command so it never reaches this stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_vld <= 1'b0;
      s2_own <= OWN_DM;
      s2_we  <= 1'b0;
    end else begin
      s2_vld <= s1_vld & !(if_flush & (s1_own == OWN_IF));
      s2_own <= s1_own;
      s2_we  <= s1_we;
    end
  end

  assign mem_en    = s1_vld;
  assign mem_we    = s1_vld & s1_we;
  assign mem_addr  = s1_addr;
  assign mem_wdata = s1_wdata;

  // An IF response in its final cycle is suppressed by a concurrent flush.
  assign if_valid = s2_vld & (s2_own == OWN_IF) & !if_flush;
  assign dm_valid = s2_vld & (s2_own == OWN_DM);
  assign if_rdata = mem_rdata;
  assign dm_rdata = s2_we ? '0 : mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned LIMIT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ready;
  logic          if_valid;
  logic [31:0]   if_rdata;
  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ready;
  logic          dm_valid;
  logic [31:0]   dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  unified_mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Single-port synchronous memory attached to the arbiter.
  logic [31:0] mem [256];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accesses are booked onto a cycle timeline.
  // A grant in cycle c occupies the memory in c+1 and responds in c+2.
  logic [31:0] ref_mem [256];
  bit          cv  [4];
  bit          cwe [4];
  logic [7:0]  ca  [4];
  logic [31:0] cd  [4];
  bit          rv  [4];
  bit          rif [4];
  bit          rwe [4];
  logic [31:0] rdat[4];
  int unsigned lost   = 0;
  logic [7:0]  last_a = '0;
  int          cyc    = 0;
  int          s0, s1, s2;
  bit          dmq, hit, e_dm, e_if, e_ifv, e_dmv;

  always @(negedge clock) begin
    s0  = cyc % 4;
    s1  = (cyc + 1) % 4;
    s2  = (cyc + 2) % 4;
    dmq = dm_rd | dm_wr;
    hit = (LIMIT != 0) && (lost == LIMIT);
    e_dm = !reset && dmq && !(if_req && hit);
    e_if = !reset && if_req && (!dmq || hit);
    chk("if_ready", 32'(if_ready), 32'(e_if));
    chk("dm_ready", 32'(dm_ready), 32'(e_dm));
    chk("mem_en",   32'(mem_en),   32'(cv[s0]));
    chk("mem_we",   32'(mem_we),   32'(cv[s0] && cwe[s0]));
    chk("mem_addr", 32'(mem_addr), 32'(last_a));
    if (cv[s0] && cwe[s0]) chk("mem_wdata", mem_wdata, cd[s0]);
    e_ifv = rv[s0] && rif[s0] && !if_flush;
    e_dmv = rv[s0] && !rif[s0];
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("dm_valid", 32'(dm_valid), 32'(e_dmv));
    if (e_ifv) chk("if_rdata", if_rdata, rdat[s0]);
    if (e_dmv) chk("dm_rdata", dm_rdata, rwe[s0] ? 32'h0 : rdat[s0]);
    if (cv[s0]) begin
      if (cwe[s0]) ref_mem[ca[s0]] = cd[s0];
      else         rdat[s1]        = ref_mem[ca[s0]];
    end
    cv[s0] = 1'b0;
    rv[s0] = 1'b0;
    if (if_flush && rv[s1] && rif[s1]) rv[s1] = 1'b0;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        cv[k] = 1'b0;
        rv[k] = 1'b0;
      end
      lost   = 0;
      last_a = '0;
    end else begin
      if (e_dm) begin
        cv[s1] = 1'b1; cwe[s1] = dm_wr; ca[s1] = dm_addr; cd[s1] = dm_wdata;
        rv[s2] = 1'b1; rif[s2] = 1'b0; rwe[s2] = dm_wr;
        last_a = dm_addr;
      end else if (e_if) begin
        cv[s1] = 1'b1; cwe[s1] = 1'b0; ca[s1] = if_addr; cd[s1] = '0;
        rv[s2] = 1'b1; rif[s2] = 1'b1; rwe[s2] = 1'b0;
        last_a = if_addr;
      end
      if (!if_req || e_if)          lost = 0;
      else if (dmq && lost < LIMIT) lost = lost + 1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    if_req = 0; if_flush = 0; dm_rd = 0; dm_wr = 0;
  endtask

  logic [9:0] pat;

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k]     = 32'hA500_0000 | 32'(k);
      ref_mem[k] = 32'hA500_0000 | 32'(k);
    end
    reset = 1; idle(); if_addr = 8'h05; dm_addr = '0; dm_wdata = '0;
    if_req = 1;
    // Reset held two cycles with a pending fetch.
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("rst_if_ready", 32'(if_ready), 32'h0);
      chk("rst_mem_en",   32'(mem_en),   32'h0);
      tick();
    end
    reset = 0;
    @(negedge clock); chk("post_rst_if_ready", 32'(if_ready), 32'h1);
    tick(); idle();
    @(negedge clock);
    chk("solo_mem_en", 32'(mem_en), 32'h1);
    chk("solo_mem_addr", 32'(mem_addr), 32'h05);
    tick();
    @(negedge clock);
    chk("solo_if_valid", 32'(if_valid), 32'h1);
    chk("solo_if_rdata", if_rdata, 32'hA500_0005);
    // Back-to-back fetches 0..3.
    for (int k = 0; k < 4; k++) begin
      if_req = 1; if_addr = AW'(k); tick();
    end
    idle(); tick(); tick();
    // DM priority over IF, then write/read.
    if_req = 1; if_addr = 8'h02; dm_wr = 1; dm_addr = 8'h10; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("prio_dm_ready", 32'(dm_ready), 32'h1);
    chk("prio_if_ready", 32'(if_ready), 32'h0);
    tick(); dm_wr = 0;
    @(negedge clock); chk("prio_if_next", 32'(if_ready), 32'h1);
    tick(); idle(); dm_rd = 1; dm_addr = 8'h10;
    tick(); idle(); tick();
    @(negedge clock);
    chk("raw_dm_valid", 32'(dm_valid), 32'h1);
    chk("raw_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    // Write then read in consecutive cycles.
    dm_wr = 1; dm_addr = 8'h11; dm_wdata = 32'h1234_5678; tick();
    dm_wr = 0; dm_rd = 1; tick(); idle();
    @(negedge clock); chk("b2b_wr_ack", dm_rdata, 32'h0);
    tick();
    @(negedge clock); chk("b2b_rd_data", dm_rdata, 32'h1234_5678);
    tick(); tick();
    // Flush kills two in-flight fetches; a same-cycle grant survives.
    if_req = 1; if_addr = 8'h01; tick();
    if_addr = 8'h02; tick();
    if_flush = 1; if_addr = 8'h07;
    @(negedge clock); chk("flush_v0", 32'(if_valid), 32'h0);
    tick(); idle();
    @(negedge clock); chk("flush_v1", 32'(if_valid), 32'h0);
    tick();
    @(negedge clock);
    chk("flush_new_valid", 32'(if_valid), 32'h1);
    chk("flush_new_rdata", if_rdata, 32'hA500_0007);
    tick();
    // Reset right after acceptance discards the fetch.
    if_req = 1; if_addr = 8'h03; tick();
    idle(); reset = 1; tick(); reset = 0;
    @(negedge clock);
    chk("midrst_if_valid", 32'(if_valid), 32'h0);
    chk("midrst_mem_en", 32'(mem_en), 32'h0);
    tick();
    @(negedge clock); chk("midrst_if_valid2", 32'(if_valid), 32'h0);
    tick();
    // Read and write together behave as a write.
    dm_rd = 1; dm_wr = 1; dm_addr = 8'h20; dm_wdata = 32'hCAFE_F00D; tick();
    idle();
    @(negedge clock); chk("rdwr_mem_we", 32'(mem_we), 32'h1);
    tick();
    @(negedge clock);
    chk("rdwr_dm_valid", 32'(dm_valid), 32'h1);
    chk("rdwr_dm_rdata", dm_rdata, 32'h0);
    tick();
    // Starvation: both held for two full periods.
    if_req = 1; dm_rd = 1; if_addr = 8'h04; dm_addr = 8'h08;
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      pat = {pat[8:0], dm_ready};
      tick();
    end
    chk("starve_pattern", 32'(pat), 32'h3DE);
    idle(); tick(); tick();
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 299) == 0);
      if_req   = ($urandom_range(0, 3) != 0);
      if_addr  = AW'($urandom_range(0, 31));
      if_flush = ($urandom_range(0, 9) == 0);
      dm_rd    = ($urandom_range(0, 2) == 0);
      dm_wr    = ($urandom_range(0, 3) == 0);
      dm_addr  = AW'($urandom_range(0, 31));
      dm_wdata = $urandom;
      tick();
    end
    reset = 0; idle();
    for (int k = 0; k < 4; k++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
